// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: machine word, RAM handshake state, arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    HIT_D = 3'd3,
    HIT_I = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side ihit/dhit ports and RAM-side handshake of the memory arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // Handshake: a requester holds iREN/dREN/dWEN with a stable address until it
  // sees a one-cycle ihit/dhit, or drops the request to abandon it. The RAM
  // completes a strobed access in the cycle it reports ramstate == ACCESS.
  logic      iREN;
  word_t     iaddr;
  logic      ihit;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dhit;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      arb_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Clear/enable counter that saturates at LAST; expired is high while count == LAST.
module arb_timeout_ctr #(
  parameter int            TW   = 8,
  parameter logic [TW-1:0] LAST = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  output logic [TW-1:0] count,
  output logic          expired
);

  assign expired = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count <= '0;
    else if (clear)               count <= '0;
    else if (enable && !expired)  count <= count + TW'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data port has strict priority over instruction fetch.
// Optional MEM_ARB_STATS_EN adds saturating ifetch/dacc/wait counters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus,
  output arb_state_t    dbg_state,
  output logic [TW-1:0] dbg_wait
`ifdef MEM_ARB_STATS_EN
  ,
  output word_t         ifetch_cnt,
  output word_t         dacc_cnt,
  output word_t         wait_cnt
`endif
);

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t state, state_n;
  logic       op_write, op_n;
  logic       ren_n, wen_n, ihit_n, dhit_n, err_n;
  word_t      addr_n, store_n, iload_n, dload_n;
  logic       in_acc, to_expired;

  assign in_acc    = (state == DACC) || (state == IACC);
  assign dbg_state = state;

  // Counter sits at zero outside an access, so each access starts from a clean count.
  arb_timeout_ctr #(.TW(TW), .LAST(TO_LAST)) u_timeout (
    .clk(CLK), .rst_n(nRST), .clear(!in_acc), .enable(in_acc),
    .count(dbg_wait), .expired(to_expired)
  );

  always_comb begin
    state_n = state;
    op_n    = op_write;
    ren_n   = bus.ramREN;
    wen_n   = bus.ramWEN;
    addr_n  = bus.ramaddr;
    store_n = bus.ramstore;
    iload_n = bus.iload;
    dload_n = bus.dload;
    ihit_n  = 1'b0;
    dhit_n  = 1'b0;
    err_n   = bus.arb_err;
    case (state)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          addr_n  = bus.daddr;
          store_n = bus.dstore;
          op_n    = bus.dWEN;
          wen_n   = bus.dWEN;
          ren_n   = !bus.dWEN;
          state_n = DACC;
        end else if (bus.iREN) begin
          addr_n  = bus.iaddr;
          ren_n   = 1'b1;
          wen_n   = 1'b0;
          state_n = IACC;
        end
      end
      DACC: begin
        // A write seen by the RAM must complete even if dWEN drops that cycle.
        if (bus.ramstate == ACCESS && (op_write || bus.dREN)) begin
          if (!op_write) dload_n = bus.ramload;
          dhit_n  = 1'b1;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          state_n = HIT_D;
        end else if (op_write ? !bus.dWEN : !bus.dREN) begin
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          state_n = IDLE;
        end else if (to_expired) begin
          err_n   = 1'b1;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          state_n = IDLE;
        end
      end
      IACC: begin
        // Redirect or drop is checked before ACCESS so a stale fetch never hits.
        if (!bus.iREN || bus.iaddr != bus.ramaddr) begin
          ren_n   = 1'b0;
          state_n = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          iload_n = bus.ramload;
          ihit_n  = 1'b1;
          ren_n   = 1'b0;
          state_n = HIT_I;
        end else if (to_expired) begin
          err_n   = 1'b1;
          ren_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      op_write     <= 1'b0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
      bus.iload    <= '0;
      bus.dload    <= '0;
      bus.ihit     <= 1'b0;
      bus.dhit     <= 1'b0;
      bus.arb_err  <= 1'b0;
    end else begin
      state        <= state_n;
      op_write     <= op_n;
      bus.ramREN   <= ren_n;
      bus.ramWEN   <= wen_n;
      bus.ramaddr  <= addr_n;
      bus.ramstore <= store_n;
      bus.iload    <= iload_n;
      bus.dload    <= dload_n;
      bus.ihit     <= ihit_n;
      bus.dhit     <= dhit_n;
      bus.arb_err  <= err_n;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic ifetch_sat, dacc_sat, wait_sat;

  arb_timeout_ctr #(.TW(32)) u_ifetch_cnt (
    .clk(CLK), .rst_n(nRST), .clear(1'b0), .enable(bus.ihit),
    .count(ifetch_cnt), .expired(ifetch_sat)
  );

  arb_timeout_ctr #(.TW(32)) u_dacc_cnt (
    .clk(CLK), .rst_n(nRST), .clear(1'b0), .enable(bus.dhit),
    .count(dacc_cnt), .expired(dacc_sat)
  );

  arb_timeout_ctr #(.TW(32)) u_wait_cnt (
    .clk(CLK), .rst_n(nRST), .clear(1'b0), .enable(in_acc),
    .count(wait_cnt), .expired(wait_sat)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, latency, redirect, timeout, async reset
// and, with MEM_ARB_STATS_EN, the statistics counters.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic       clk;
  logic       nrst;
  arb_state_t dbg_state;
  logic [7:0] dbg_wait;
`ifdef MEM_ARB_STATS_EN
  word_t      ifetch_cnt, dacc_cnt, wait_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_dacc;
  bit saw_hit;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(16), .TW(8)) dut (
    .CLK(clk),
    .nRST(nrst),
    .bus(bus.slave),
    .dbg_state(dbg_state),
    .dbg_wait(dbg_wait)
`ifdef MEM_ARB_STATS_EN
    ,
    .ifetch_cnt(ifetch_cnt),
    .dacc_cnt(dacc_cnt),
    .wait_cnt(wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic stat_access(input bit is_data, input word_t addr, input word_t word);
    if (is_data) begin bus.dREN = 1'b1; bus.daddr = addr; end
    else begin bus.iREN = 1'b1; bus.iaddr = addr; end
    bus.ramstate = BUSY;
    step();
    step();
    bus.ramstate = ACCESS; bus.ramload = word;
    step();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    step();
  endtask
`endif

  initial begin
    nrst = 1'b0;
    idle_inputs();
    repeat (2) step();

    // reset state
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_ihit", 32'(bus.ihit), 32'd0);
    check("rst_dhit", 32'(bus.dhit), 32'd0);
    check("rst_ramren", 32'(bus.ramREN), 32'd0);
    check("rst_ramwen", 32'(bus.ramWEN), 32'd0);
    check("rst_err", 32'(bus.arb_err), 32'd0);
    check("rst_iload", bus.iload, 32'd0);
    check("rst_dload", bus.dload, 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_ramstore", bus.ramstore, 32'd0);
    check("rst_wait", 32'(dbg_wait), 32'd0);
    nrst = 1'b1;
    step();

    // data read, ACCESS on first strobe cycle
    bus.dREN = 1'b1; bus.daddr = 32'h40;
    bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    step();
    check("rd_state", 32'(dbg_state), 32'(DACC));
    check("rd_ramren", 32'(bus.ramREN), 32'd1);
    check("rd_ramaddr", bus.ramaddr, 32'h40);
    check("rd_dhit_early", 32'(bus.dhit), 32'd0);
    step();
    check("rd_dhit", 32'(bus.dhit), 32'd1);
    check("rd_dload", bus.dload, 32'hDEADBEEF);
    check("rd_ihit", 32'(bus.ihit), 32'd0);
    check("rd_strobe_off", 32'(bus.ramREN), 32'd0);
    bus.dREN = 1'b0; bus.ramstate = FREE; bus.ramload = '0;
    step();
    check("rd_dhit_pulse", 32'(bus.dhit), 32'd0);
    check("rd_dload_hold", bus.dload, 32'hDEADBEEF);
    check("rd_idle", 32'(dbg_state), 32'(IDLE));

    // simultaneous fetch and write: write first
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h12345678;
    step();
    check("wr_ramwen", 32'(bus.ramWEN), 32'd1);
    check("wr_ramren", 32'(bus.ramREN), 32'd0);
    check("wr_ramaddr", bus.ramaddr, 32'h80);
    check("wr_ramstore", bus.ramstore, 32'h12345678);
    bus.ramstate = ACCESS; bus.ramload = 32'hFFFF0000;
    step();
    check("wr_dhit", 32'(bus.dhit), 32'd1);
    check("wr_ihit", 32'(bus.ihit), 32'd0);
    check("wr_dload_kept", bus.dload, 32'hDEADBEEF);
    check("wr_wen_off", 32'(bus.ramWEN), 32'd0);
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    step();
    check("wr_hit_no_accept", 32'(bus.ramREN), 32'd0);
    step();
    check("if_ramren", 32'(bus.ramREN), 32'd1);
    check("if_ramaddr", bus.ramaddr, 32'h300);
    bus.ramstate = ACCESS; bus.ramload = 32'hA5A50300;
    step();
    check("if_ihit", 32'(bus.ihit), 32'd1);
    check("if_iload", bus.iload, 32'hA5A50300);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    step();
    check("if_ihit_pulse", 32'(bus.ihit), 32'd0);

    // fetch redirect while RAM busy
    bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramstate = BUSY;
    step();
    check("rdr_addr1", bus.ramaddr, 32'h100);
    step();
    check("rdr_wait", 32'(dbg_state), 32'(IACC));
    bus.iaddr = 32'h200;
    step();
    check("rdr_abort", 32'(dbg_state), 32'(IDLE));
    check("rdr_no_ihit", 32'(bus.ihit), 32'd0);
    check("rdr_ren_off", 32'(bus.ramREN), 32'd0);
    step();
    check("rdr_addr2", bus.ramaddr, 32'h200);
    check("rdr_ren2", 32'(bus.ramREN), 32'd1);
    step();
    check("rdr_busy_no_hit", 32'(bus.ihit), 32'd0);
    bus.ramstate = ACCESS; bus.ramload = 32'h22220200;
    step();
    check("rdr_ihit", 32'(bus.ihit), 32'd1);
    check("rdr_iload", bus.iload, 32'h22220200);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    step();

    // timeout with RAM stuck BUSY
    bus.dREN = 1'b1; bus.daddr = 32'h44; bus.ramstate = BUSY;
    step();
    n_dacc = (dbg_state == DACC) ? 1 : 0;
    saw_hit = 1'b0;
    for (int k = 0; k < 40 && dbg_state == DACC; k++) begin
      step();
      if (bus.dhit) saw_hit = 1'b1;
      if (dbg_state == DACC) n_dacc++;
    end
    check("to_cycles", 32'(n_dacc), 32'd16);
    check("to_state", 32'(dbg_state), 32'(IDLE));
    check("to_err", 32'(bus.arb_err), 32'd1);
    check("to_no_dhit", 32'(saw_hit), 32'd0);
    check("to_ren_off", 32'(bus.ramREN), 32'd0);
    bus.dREN = 1'b0; bus.ramstate = FREE;
    repeat (2) step();
    check("to_err_sticky", 32'(bus.arb_err), 32'd1);
    bus.iREN = 1'b1; bus.iaddr = 32'h600; bus.ramstate = ACCESS; bus.ramload = 32'h66660600;
    step();
    step();
    check("to_after_ihit", 32'(bus.ihit), 32'd1);
    check("to_err_still", 32'(bus.arb_err), 32'd1);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    step();

    // async reset in the middle of a data access
    bus.dREN = 1'b1; bus.daddr = 32'h60; bus.ramstate = BUSY;
    step();
    check("ar_in_dacc", 32'(dbg_state), 32'(DACC));
    nrst = 1'b0;
    #1;
    check("ar_state", 32'(dbg_state), 32'(IDLE));
    check("ar_ramren", 32'(bus.ramREN), 32'd0);
    check("ar_ramaddr", bus.ramaddr, 32'd0);
    check("ar_err", 32'(bus.arb_err), 32'd0);
    check("ar_iload", bus.iload, 32'd0);
    check("ar_dload", bus.dload, 32'd0);
    bus.dREN = 1'b0; bus.ramstate = FREE;
    step();
    nrst = 1'b1;
    check("ar_no_dhit", 32'(bus.dhit), 32'd0);
    bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = ACCESS; bus.ramload = 32'h55550500;
    step();
    check("ar_if_addr", bus.ramaddr, 32'h500);
    step();
    check("ar_if_ihit", 32'(bus.ihit), 32'd1);
    check("ar_if_iload", bus.iload, 32'h55550500);
    check("ar_if_dhit", 32'(bus.dhit), 32'd0);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    step();

`ifdef MEM_ARB_STATS_EN
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
    for (int i = 0; i < 7; i++) stat_access(i >= 5, 32'(i * 4), 32'(32'hC0DE0000 + i));
    check("st_ifetch", ifetch_cnt, 32'd5);
    check("st_dacc", dacc_cnt, 32'd2);
    check("st_wait", wait_cnt, 32'd14);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side end of the ihit/dhit protocol that the pipeline stall/flush logic consumes.
- Arbitrates between the instruction-fetch port and the data port for a single-ported RAM.
- Sequences each access against the RAM handshake.
- Returns registered one-cycle ihit/dhit pulses with load data; these drive the pipeline's stall, enable and flush decisions.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles an access may wait for ramstate==ACCESS before it is abandoned.
- TW, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request, held until ihit or dropped
- iaddr  in  32  instruction address (word_t)
- ihit  out  1  one-cycle pulse: iload valid
- iload  out  32  fetched instruction
- dREN  in  1  data read request
- dWEN  in  1  data write request (dREN and dWEN both high is illegal; dWEN wins)
- daddr  in  32  data address
- dstore  in  32  write data
- dhit  out  1  one-cycle pulse: data access complete, dload valid on reads
- dload  out  32  read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ramstate==ACCESS
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- arb_err  out  1  sticky: an access timed out

Behaviour:
- Reset (nRST low, async):
  - State IDLE.
  - ihit, dhit, ramREN, ramWEN, arb_err = 0.
  - iload, dload, ramaddr, ramstore = 0.
  - Timeout counter = 0.
  - Reset mid-access abandons the access silently; no hit is issued.
- State IDLE:
  - If dREN|dWEN: latch daddr and dstore, latch the op (read or write), go to DACC.
  - Else if iREN: latch iaddr, go to IACC.
  - Data has strict priority.
- State DACC: ram strobes and ramaddr/ramstore are driven from the latched values, registered, from the cycle after acceptance.
- State IACC: same, with ramREN only.
- ramstate==ACCESS in DACC/IACC:
  - Capture ramload into dload (reads only) or iload.
  - Go to HIT_D or HIT_I.
- State HIT_D / HIT_I:
  - dhit (resp. ihit) = 1 for exactly this cycle.
  - RAM strobes = 0.
  - Next state IDLE.
  - Minimum latency from request to hit: 3 cycles (accept, RAM ACCESS, hit), given ACCESS on the first strobe cycle.
- Requester drops its request in DACC/IACC before ACCESS:
  - Go to IDLE the next cycle, strobes off, no hit.
  - A write that has already seen ACCESS always completes.
- iaddr differs from the latched address while in IACC (fetch redirect): abort and return to IDLE. Re-arbitration follows normally; a stale fetch is never returned.
- ramstate==ERROR or BUSY: keep strobes asserted and wait.
- Timeout counter:
  - Counts cycles spent in DACC/IACC; cleared on entry.
  - At TIMEOUT_CYCLES: set arb_err (sticky until reset), issue no hit, go to IDLE.
- Load data: iload/dload hold their last captured value between hits.
- Same-cycle dhit: the arbiter never accepts a new request in a HIT state, so a request held across the hit cycle is re-accepted only from IDLE.

Optional Feature:
- MEM_ARB_STATS_EN defined adds three 32-bit saturating output counters:
  - ifetch_cnt: ihit pulses.
  - dacc_cnt: dhit pulses.
  - wait_cnt: cycles in DACC/IACC.
- Counters clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg: word_t and ramstate_t (existing); add arb_state_t enum {IDLE, DACC, IACC, HIT_D, HIT_I}.
- One natural sub-module, arb_timeout_ctr: clear/enable/expired counter of width TW. Reused by the stats counters under the macro.

Test Plan:
- dREN=1, daddr=0x40, RAM returns ACCESS on the first strobe with ramload=0xDEADBEEF -> dhit pulses 3 cycles after the request, dload=0xDEADBEEF, ihit=0.
- iREN=1 and dWEN=1 in the same cycle, daddr=0x80, dstore=0x12345678 -> write serviced first (ramWEN, ramstore=0x12345678), dhit; then ramREN at iaddr and ihit.
- iREN=1, iaddr=0x100, RAM BUSY for 4 cycles, iaddr changes to 0x200 in cycle 2 -> no ihit for 0x100; next access at ramaddr=0x200 and ihit with its data.
- dREN held with ramstate=BUSY forever, TIMEOUT_CYCLES=16 -> after 16 DACC cycles arb_err=1, no dhit, state IDLE; arb_err stays 1 until nRST.
- nRST asserted mid-DACC -> all outputs 0 immediately (async); after release, a new iREN is serviced normally.
- With MEM_ARB_STATS_EN: 5 fetches and 2 loads, each with 1 BUSY cycle -> ifetch_cnt=5, dacc_cnt=2, wait_cnt=14.
